// File: rtl/csr_file.sv
// Machine-mode CSR file: storage for the trap/interrupt CSRs, 64-bit cycle and
// retired-instruction counters, trap entry / mret sequencing, and a
// combinational read port that forwards a same-cycle write.
module csr_file #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] readAddress,
  output logic [31:0] readData,
  output logic        readIllegal,
  input  logic        csrDestinationEnable,
  input  logic [11:0] destinationCSR,
  input  logic [31:0] csrWriteData,
  input  logic        retire,
  input  logic        interrupt,
  input  logic        trapEnter,
  input  logic [31:0] trapPC,
  input  logic [31:0] trapCause,
  input  logic        mret,
  output logic [31:0] trapVector,
  output logic [31:0] returnPC,
  output logic        interruptPending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mstatus_mie, mstatus_mpie, mie_meie, mip_meip;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic [63:0] mcycle_next, minstret_next;
  logic [31:0] stored_value, write_masked;
  logic        write_hits_read;

  // Only the M-mode CSRs with storage accept writes; counters' user aliases,
  // mip and mhartid are read-only.
  function automatic logic is_writable(input logic [11:0] addr);
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Value a write would leave behind once unimplemented bits are dropped;
  // mstatus.MPP is hardwired to machine mode.
  function automatic logic [31:0] mask_write(input logic [11:0] addr, input logic [31:0] wd);
    case (addr)
      A_MSTATUS: return {19'd0, 2'b11, 3'd0, wd[7], 3'd0, wd[3], 3'd0};
      A_MIE:     return {20'd0, wd[11], 11'd0};
      A_MEPC:    return {wd[31:2], 2'b00};
      default:   return wd;
    endcase
  endfunction

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign write_masked = mask_write(destinationCSR, csrWriteData);
  assign wr_mstatus   = csrDestinationEnable && (destinationCSR == A_MSTATUS);
  assign wr_mie       = csrDestinationEnable && (destinationCSR == A_MIE);
  assign wr_mtvec     = csrDestinationEnable && (destinationCSR == A_MTVEC);
  assign wr_mscratch  = csrDestinationEnable && (destinationCSR == A_MSCRATCH);
  assign wr_mepc      = csrDestinationEnable && (destinationCSR == A_MEPC);
  assign wr_mcause    = csrDestinationEnable && (destinationCSR == A_MCAUSE);
  assign wr_mcycle    = csrDestinationEnable && (destinationCSR == A_MCYCLE);
  assign wr_mcycleh   = csrDestinationEnable && (destinationCSR == A_MCYCLEH);
  assign wr_minstret  = csrDestinationEnable && (destinationCSR == A_MINSTRET);
  assign wr_minstreth = csrDestinationEnable && (destinationCSR == A_MINSTRETH);

  assign write_hits_read = csrDestinationEnable && (destinationCSR == readAddress)
                           && is_writable(destinationCSR);

  // Read mux over stored state, then forward a same-cycle write to the reader.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    stored_value = 32'd0;
    readIllegal  = 1'b0;
    case (readAddress)
      A_MSTATUS:              stored_value = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      A_MIE:                  stored_value = {20'd0, mie_meie, 11'd0};
      A_MTVEC:                stored_value = mtvec;
      A_MSCRATCH:             stored_value = mscratch;
      A_MEPC:                 stored_value = mepc;
      A_MCAUSE:               stored_value = mcause;
      A_MIP:                  stored_value = {20'd0, mip_meip, 11'd0};
      A_MCYCLE, A_CYCLE:      stored_value = mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:    stored_value = mcycle[63:32];
      A_MINSTRET, A_INSTRET:  stored_value = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: stored_value = minstret[63:32];
      A_MHARTID:              stored_value = HART_ID;
      default:                readIllegal  = 1'b1;
    endcase
    readData = write_hits_read ? write_masked : stored_value;
  end

  // Counter next-state: a write replaces only the half it targets; the other
  // half follows the normal increment (and carry from the old low half).
  always_comb begin
    mcycle_next   = mcycle + 64'd1;
    minstret_next = minstret + {63'd0, retire};
    if (wr_mcycle)    mcycle_next[31:0]    = csrWriteData;
    if (wr_mcycleh)   mcycle_next[63:32]   = csrWriteData;
    if (wr_minstret)  minstret_next[31:0]  = csrWriteData;
    if (wr_minstreth) minstret_next[63:32] = csrWriteData;
  end

  // CSR state update: trap entry outranks mret, which outranks a software write.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec        <= RESET_MTVEC;
      mscratch     <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
      mcycle       <= 64'd0;
      minstret     <= 64'd0;
    end else begin
      mip_meip <= interrupt;
      mcycle   <= mcycle_next;
      minstret <= minstret_next;

      if (trapEnter) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie  <= csrWriteData[3];
        mstatus_mpie <= csrWriteData[7];
      end

      if (trapEnter)    mepc <= trapPC & ~32'd3;
      else if (wr_mepc) mepc <= write_masked;

      if (trapEnter)      mcause <= trapCause;
      else if (wr_mcause) mcause <= csrWriteData;

      if (wr_mie)      mie_meie <= csrWriteData[11];
      if (wr_mtvec)    mtvec    <= csrWriteData;
      if (wr_mscratch) mscratch <= csrWriteData;
    end
  end

  assign trapVector       = {mtvec[31:2], 2'b00};
  assign returnPC         = mepc;
  assign interruptPending = mip_meip & mie_meie & mstatus_mie;

endmodule
